// File: rtl/fflags_pipe_if.sv
// Execute/Memory-stage FP control bundle between pipeline control and fflags_pipe.
// Combinational frm/stall outputs; SetFflagsM is one register behind the E flag source.
interface fflags_pipe_if #(
   parameter int XLEN = 64
);
   logic            StallE;
   logic            StallM;
   logic            FlushE;
   logic            FlushM;
   logic            FpInstrE;
   logic [2:0]      RmE;
   logic [4:0]      FpuFlagsE;
   logic            FpuFlagValidE;
   logic            DivStartE;
   logic            DivDoneE;
   logic [4:0]      DivFlags;
   logic [2:0]      FRM_REGW;
   logic            WriteFRMM;
   logic [XLEN-1:0] CSRWriteValM;
   logic [11:0]     CSRAdrM;
   logic [2:0]      FRMResolvedE;
   logic            IllegalFRME;
   logic            FrmHazardE;
   logic            DivBusyE;
   logic            DivAbortE;
   logic [4:0]      SetFflagsM;

   modport master (
      output StallE, StallM, FlushE, FlushM, FpInstrE, RmE, FpuFlagsE, FpuFlagValidE,
             DivStartE, DivDoneE, DivFlags, FRM_REGW, WriteFRMM, CSRWriteValM, CSRAdrM,
      input  FRMResolvedE, IllegalFRME, FrmHazardE, DivBusyE, DivAbortE, SetFflagsM
   );

   modport slave (
      input  StallE, StallM, FlushE, FlushM, FpInstrE, RmE, FpuFlagsE, FpuFlagValidE,
             DivStartE, DivDoneE, DivFlags, FRM_REGW, WriteFRMM, CSRWriteValM, CSRAdrM,
      output FRMResolvedE, IllegalFRME, FrmHazardE, DivBusyE, DivAbortE, SetFflagsM
   );
endinterface

// File: rtl/fflags_pipe.sv
// FP rounding-mode resolve, divider tracking and fflags E->M pipe; SetFflagsM 1-cycle latency.
// Stalls hold state, flushes clear synchronously; FRM_BYPASS_EN forwards M-stage frm writes.
module fflags_pipe #(
   parameter int XLEN = 64
) (
   input logic          clk,
   input logic          reset,
   fflags_pipe_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

   div_state_t      state, state_nxt;
   logic [4:0]      held_flags;
   logic [4:0]      flags_m;
   logic [4:0]      flags_e;
   logic [XLEN-1:0] csr_val;
   logic [2:0]      dyn_frm;
   logic [2:0]      frm_src;
   logic            dyn_rm;
   logic            capture;
   logic            unused_csr_hi;

   assign csr_val       = bus.CSRWriteValM;
   assign unused_csr_hi = ^csr_val[XLEN-1:8];

   // A write to the fcsr image carries frm in bits 7:5; a write to frm itself in bits 2:0.
   assign dyn_frm = (bus.CSRAdrM == 12'h003) ? csr_val[7:5] : csr_val[2:0];
   assign dyn_rm  = (bus.RmE == 3'b111);

`ifdef FRM_BYPASS_EN
   assign frm_src        = bus.WriteFRMM ? dyn_frm : bus.FRM_REGW;
   assign bus.FrmHazardE = 1'b0;
`else
   assign frm_src        = bus.FRM_REGW;
   assign bus.FrmHazardE = bus.FpInstrE & dyn_rm & bus.WriteFRMM;
`endif

   assign bus.FRMResolvedE = dyn_rm ? frm_src : bus.RmE;
   assign bus.IllegalFRME  = bus.FpInstrE & (bus.FRMResolvedE >= 3'd5);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.DivBusyE  = 1'b0;
      bus.DivAbortE = 1'b0;
      capture       = 1'b0;
      case (state)
         IDLE: if (bus.DivStartE && !bus.FlushE) state_nxt = BUSY;
         BUSY: begin
            bus.DivBusyE = 1'b1;
            if (bus.FlushE) begin
               state_nxt     = IDLE;
               bus.DivAbortE = 1'b1;
            end else if (bus.DivDoneE) begin
               state_nxt = DONE;
               capture   = 1'b1;
            end
         end
         DONE: if (bus.FlushE || !bus.StallE) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                held_flags <= 5'b0;
      else if (capture)         held_flags <= bus.DivFlags;
      else if (state_nxt != DONE) held_flags <= 5'b0;
   end

   assign flags_e = (state == DONE)     ? held_flags :
                    bus.FpuFlagValidE   ? bus.FpuFlagsE : 5'b0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)            flags_m <= 5'b0;
      else if (bus.FlushM)  flags_m <= 5'b0;
      else if (!bus.StallM) flags_m <= flags_e;
   end

   assign bus.SetFflagsM = flags_m;
endmodule
